// File: rtl/lcd_text_frame_writer.sv
// HD44780 text-frame writer: latches a frame of characters on start, optionally
// clears the display, then writes each selected row (set-address byte followed
// by the row's characters) over the 4-bit bus with its own E-strobe timing.
// The panel is assumed to already be initialised in 4-bit mode.
module lcd_text_frame_writer #(
  parameter int CLK_FREQ    = 50_000_000,
  parameter int LINE_COUNT  = 2,
  parameter int LINE_LENGTH = 16
) (
  input  logic                                  CLK,
  input  logic                                  RESET,
  input  logic                                  start,
  input  logic                                  clear_first,
  input  logic [LINE_COUNT-1:0]                 line_mask,
  input  logic [8*LINE_COUNT*LINE_LENGTH-1:0]   text,
  output logic                                  busy,
  output logic                                  done,
  output logic [3:0]                            LCD_D,
  output logic                                  LCD_E,
  output logic                                  LCD_RS,
  output logic                                  LCD_RW
);

  localparam int T_E    = CLK_FREQ / 1_000_000;
  localparam int T_CMD  = 53 * T_E;
  localparam int T_CLR  = CLK_FREQ / 500;
  localparam int CNT_W  = $clog2(T_CLR + 1);
  localparam int ROW_W  = $clog2(LINE_COUNT + 1);
  localparam int COL_W  = (LINE_LENGTH > 1) ? $clog2(LINE_LENGTH) : 1;
  localparam int TEXT_W = 8 * LINE_COUNT * LINE_LENGTH;

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_SETUP, S_E_HIGH, S_E_LOW, S_SETTLE, S_DONE
  } state_t;

  state_t                 state_q;
  logic [CNT_W-1:0]       cnt_q;
  logic [ROW_W-1:0]       row_q;
  logic [COL_W-1:0]       col_q;
  logic                   addr_sent_q;
  logic                   clr_pend_q;
  logic                   long_settle_q;
  logic                   nib_lo_q;
  logic [3:0]             lo_nib_q;
  logic [LINE_COUNT-1:0]  mask_q;
  logic [TEXT_W-1:0]      text_q;
  logic                   busy_q;
  logic                   done_q;
  logic [3:0]             lcd_d_q;
  logic                   lcd_e_q;
  logic                   lcd_rs_q;

  logic                   scan_hit;
  logic [ROW_W-1:0]       scan_row;
  logic [7:0]             char_byte;
  logic [7:0]             load_byte;
  logic                   load_rs;

  // DDRAM base address of each display row
  function automatic logic [7:0] row_base(input logic [ROW_W-1:0] r);
    case (int'(r))
      0:       row_base = 8'h00;
      1:       row_base = 8'h40;
      2:       row_base = 8'h14;
      default: row_base = 8'h54;
    endcase
  endfunction

  // Find the lowest selected row at or after the current row, and pick the byte LOAD would send
  always_comb begin
    scan_hit  = 1'b0;
    scan_row  = '0;
    char_byte = 8'h00;
    for (int r = LINE_COUNT - 1; r >= 0; r--) begin
      if (ROW_W'(r) >= row_q && mask_q[r]) begin
        scan_hit = 1'b1;
        scan_row = ROW_W'(r);
      end
    end
    for (int r = 0; r < LINE_COUNT; r++) begin
      for (int c = 0; c < LINE_LENGTH; c++) begin
        if (scan_row == ROW_W'(r) && col_q == COL_W'(c)) begin
          char_byte = text_q[8*(r*LINE_LENGTH+c) +: 8];
        end
      end
    end
    if (clr_pend_q) begin
      load_byte = 8'h01;
      load_rs   = 1'b0;
    end else if (!addr_sent_q) begin
      load_byte = 8'h80 | row_base(scan_row);
      load_rs   = 1'b0;
    end else begin
      load_byte = char_byte;
      load_rs   = 1'b1;
    end
  end

  // Frame text is a data payload: captured on accept, no reset needed
  always_ff @(posedge CLK) begin
    if (state_q == S_IDLE && start) begin
      text_q <= text;
    end
  end

  // Frame sequencer: byte selection, nibble strobing, settle delays and handshake outputs
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q       <= S_IDLE;
      cnt_q         <= '0;
      row_q         <= '0;
      col_q         <= '0;
      addr_sent_q   <= 1'b0;
      clr_pend_q    <= 1'b0;
      long_settle_q <= 1'b0;
      nib_lo_q      <= 1'b0;
      lo_nib_q      <= 4'h0;
      mask_q        <= '0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      lcd_d_q       <= 4'h0;
      lcd_e_q       <= 1'b0;
      lcd_rs_q      <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            mask_q      <= line_mask;
            clr_pend_q  <= clear_first;
            row_q       <= '0;
            col_q       <= '0;
            addr_sent_q <= 1'b0;
            busy_q      <= 1'b1;
            state_q     <= S_LOAD;
          end
        end
        S_LOAD: begin
          if (clr_pend_q || scan_hit) begin
            lcd_d_q       <= load_byte[7:4];
            lo_nib_q      <= load_byte[3:0];
            lcd_rs_q      <= load_rs;
            long_settle_q <= clr_pend_q;
            nib_lo_q      <= 1'b0;
            state_q       <= S_SETUP;
            if (clr_pend_q) begin
              clr_pend_q <= 1'b0;
            end else if (!addr_sent_q) begin
              addr_sent_q <= 1'b1;
              row_q       <= scan_row;
            end else if (col_q == COL_W'(LINE_LENGTH - 1)) begin
              col_q       <= '0;
              addr_sent_q <= 1'b0;
              row_q       <= scan_row + 1'b1;
            end else begin
              col_q <= col_q + 1'b1;
            end
          end else begin
            done_q  <= 1'b1;
            state_q <= S_DONE;
          end
        end
        S_SETUP: begin
          lcd_e_q <= 1'b1;
          cnt_q   <= CNT_W'(T_E - 1);
          state_q <= S_E_HIGH;
        end
        S_E_HIGH: begin
          if (cnt_q == '0) begin
            lcd_e_q <= 1'b0;
            cnt_q   <= CNT_W'(T_E - 1);
            state_q <= S_E_LOW;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        S_E_LOW: begin
          if (cnt_q == '0) begin
            if (!nib_lo_q) begin
              nib_lo_q <= 1'b1;
              lcd_d_q  <= lo_nib_q;
              state_q  <= S_SETUP;
            end else begin
              nib_lo_q <= 1'b0;
              cnt_q    <= long_settle_q ? CNT_W'(T_CLR - 1) : CNT_W'(T_CMD - 1);
              state_q  <= S_SETTLE;
            end
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        S_SETTLE: begin
          if (cnt_q == '0) begin
            state_q <= S_LOAD;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        S_DONE: begin
          done_q      <= 1'b0;
          busy_q      <= 1'b0;
          row_q       <= '0;
          col_q       <= '0;
          addr_sent_q <= 1'b0;
          state_q     <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign LCD_D  = lcd_d_q;
  assign LCD_E  = lcd_e_q;
  assign LCD_RS = lcd_rs_q;
  assign LCD_RW = 1'b0;

endmodule

// File: doc/lcd_text_frame_writer.md
# lcd_text_frame_writer

Parametrised HD44780 text-frame writer driving the LCD 4-bit bus directly with its own E-strobe and delay timing, with no separate transfer sub-block. It latches a full frame of LINE_COUNT × LINE_LENGTH characters on `start`. It optionally clears the display first, then rewrites only the rows selected by a mask, with per-row DDRAM addressing for 1–4 line panels. Power-on LCD initialisation is owned by a separate init block; this block assumes a display already in 4-bit mode.

## Interface
- CLK_FREQ, 50_000_000, clock frequency in Hz.
- LINE_COUNT, 2, number of display rows, 1..4.
- LINE_LENGTH, 16, characters per row, 1..40.
- CLK  input  1  system clock, rising edge.
- RESET  input  1  asynchronous, active-high reset.
- start  input  1  request a frame write; sampled only in IDLE.
- clear_first  input  1  send Clear Display (0x01) before any row; latched on start.
- line_mask  input  LINE_COUNT  bit r=1 rewrites row r; latched on start.
- text  input  8*LINE_COUNT*LINE_LENGTH  char c of row r at text[8*(r*LINE_LENGTH+c) +: 8], c=0 leftmost; latched on start.
- busy  output  1  high from the cycle after start is accepted through the DONE cycle.
- done  output  1  one-cycle pulse when the frame is complete.
- LCD_D  output  4  LCD data nibble.
- LCD_E  output  1  LCD enable strobe.
- LCD_RS  output  1  0 = command, 1 = data.
- LCD_RW  output  1  constant 0 (write only).

## Operation
- All outputs are registered. Reset values: LCD_D=0, LCD_E=0, LCD_RS=0, LCD_RW=0, busy=0, done=0. State=IDLE; all internal counters are 0.
- Derived constants:
  - T_E = CLK_FREQ/1_000_000 (1 µs).
  - T_CMD = 53·T_E.
  - T_CLR = CLK_FREQ/500 (2 ms).
  - Delay counter width = $clog2(T_CLR+1).
- Row DDRAM base: row0 0x00, row1 0x40, row2 0x14, row3 0x54. The set-address byte is 0x80|base.
- States: IDLE, LOAD, SETUP, E_HIGH, E_LOW, SETTLE, DONE. A nibble flag selects high or low nibble.
- IDLE: on start=1, latch text, line_mask and clear_first, then go to LOAD. Start is ignored in every other state.
- LOAD selects the next byte in this order:
  - 0x01 (RS=0) if the clear is still pending.
  - Otherwise, for each row r ascending with mask bit set: the set-address byte (RS=0), then LINE_LENGTH characters (RS=1), c=0 first.
  - Rows whose mask bit is 0 are skipped.
  - With no bytes remaining, go to DONE.
- Per nibble, high nibble first:
  - SETUP: 1 cycle, LCD_D/LCD_RS valid, E=0.
  - E_HIGH: T_E cycles, E=1.
  - E_LOW: T_E cycles, E=0, LCD_D held.
  - After the high nibble, return to SETUP with the low nibble. After the low nibble, go to SETTLE.
- SETTLE: T_CLR cycles after 0x01, otherwise T_CMD cycles. Then go to LOAD.
- DONE: done=1 for one cycle, busy=1 in that cycle, then IDLE.
- Inputs changing mid-frame have no effect; only latched copies are used.
- The row and column counters wrap to 0 at the end of a frame.

## Timing
- Start accepted at edge N: busy=1 and state=LOAD from cycle N+1. The first SETUP is at N+2.
- Byte cost: 2·(1+2·T_E) + settle cycles, plus 1 LOAD cycle.
- Frame with B bytes, no clear: B·(3+4·T_E+T_CMD) + 2 cycles from accept to done (the final LOAD plus DONE). A clear adds T_CLR−T_CMD.
- Empty frame (mask=0, clear_first=0): LOAD at N+1, DONE with done=1 at N+2, IDLE at N+3.
- start coincident with the DONE cycle is ignored. start in the first IDLE cycle is accepted.
- RESET mid-operation, including while E=1: all outputs drop to reset values immediately. The LCD may hold a half-written byte, and recovery is the caller's responsibility via the init block.

## Test plan
All scenarios use CLK_FREQ=4_000_000, so T_E=4, T_CMD=212, T_CLR=8000.

1. Reset, hold idle 100 cycles → all outputs 0, no E edges.
2. LINE_COUNT=2, LINE_LENGTH=2, mask=11, clear_first=0, row0 "AB", row1 "CD", start pulse → bytes 0x80,0x41,0x42,0xC0,0x43,0x44.
   - RS pattern 0,1,1,0,1,1.
   - Nibbles 8,0,4,1,4,2,C,0,4,3,4,4.
   - Each E-high lasts 4 cycles.
   - done exactly 6·231+2 = 1388 cycles after accept.
3. Same configuration, mask=10, clear_first=1 → 0x01 (RS=0) followed by ≥8000 idle cycles before the next E, then 0xC0,0x43,0x44. Row 0 is never written.
4. Assert start during a frame and toggle text mid-frame → no restart, output bytes match the frame latched at accept, a single done pulse.
5. LINE_COUNT=4, LINE_LENGTH=1, mask=1000 → first byte is 0xD4, then the single row-3 character, then done.
6. Assert RESET while LCD_E=1 → LCD_E=0 and busy=0 in the same cycle. A new start after release produces a correct full frame.
